// File: rtl/cache_ctrl_param.sv
// Direct-mapped cache controller with a parameterised line size and a choice of
// write-back or write-through policy. One CPU request is handled at a time, and
// whole lines are moved to and from memory.
module cache_ctrl_param #(
  parameter int unsigned AW         = 32,
  parameter int unsigned INDEX_W    = 10,
  parameter int unsigned WORDS      = 4,
  parameter bit          WRITE_BACK = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [AW-1:0]         cpu_req_addr,
  input  logic [31:0]           cpu_req_data,
  input  logic                  cpu_req_rw,
  input  logic                  cpu_req_valid,
  output logic [31:0]           cpu_res_data,
  output logic                  cpu_res_ready,
  output logic [AW-1:0]         mem_req_addr,
  output logic [32*WORDS-1:0]   mem_req_data,
  output logic                  mem_req_rw,
  output logic                  mem_req_valid,
  input  logic [32*WORDS-1:0]   mem_data,
  input  logic                  mem_ready,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
);

  localparam int unsigned WSEL_W = $clog2(WORDS);
  localparam int unsigned OFF_W  = 2 + WSEL_W;
  localparam int unsigned TAG_W  = AW - INDEX_W - OFF_W;
  localparam int unsigned LINES  = 2 ** INDEX_W;

  typedef logic [WORDS-1:0][31:0] line_t;

  typedef enum logic [2:0] {
    StIdle,
    StCompare,
    StWriteBack,
    StAllocate,
    StWriteThru
  } state_e;

  state_e             state_q;
  logic [TAG_W-1:0]   req_tag_q;
  logic [INDEX_W-1:0] req_index_q;
  logic [WSEL_W-1:0]  req_word_q;
  logic [31:0]        req_data_q;
  logic               req_rw_q;
  logic               refill_q;   // this COMPARE follows a line fill
  logic [LINES-1:0]   valid_q;
  logic [LINES-1:0]   dirty_q;

  logic [TAG_W-1:0]   tag_mem  [LINES];
  line_t              data_mem [LINES];

  line_t              cur_line;
  line_t              upd_line;
  logic [TAG_W-1:0]   cur_tag;
  logic               hit;
  logic               mem_ack;
  logic               unused_addr_bits;

  // Byte offset within a word is irrelevant to a word-granular cache.
  assign unused_addr_bits = ^cpu_req_addr[1:0];

  assign cur_line = data_mem[req_index_q];
  assign cur_tag  = tag_mem[req_index_q];
  assign hit      = valid_q[req_index_q] && (cur_tag == req_tag_q);
  assign mem_ack  = mem_ready && mem_req_valid;

  // Line image with the requested word replaced by the write data.
  always_comb begin
    upd_line              = cur_line;
    upd_line[req_word_q]  = req_data_q;
  end

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Tag and data arrays carry no reset; valid_q gates every use of them.
  always_ff @(posedge clk) begin
    if (state_q == StCompare && hit && req_rw_q) begin
      data_mem[req_index_q] <= upd_line;
    end else if (state_q == StAllocate && mem_ack) begin
      data_mem[req_index_q] <= mem_data;
      tag_mem[req_index_q]  <= req_tag_q;
    end
  end

  // Controller FSM with registered CPU/memory outputs and line status bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      req_tag_q     <= '0;
      req_index_q   <= '0;
      req_word_q    <= '0;
      req_data_q    <= '0;
      req_rw_q      <= 1'b0;
      refill_q      <= 1'b0;
      valid_q       <= '0;
      dirty_q       <= '0;
      hit_count     <= '0;
      miss_count    <= '0;
      cpu_res_ready <= 1'b0;
      cpu_res_data  <= '0;
      mem_req_valid <= 1'b0;
      mem_req_rw    <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_data  <= '0;
    end else begin
      cpu_res_ready <= 1'b0;
      case (state_q)
        StIdle: begin
          if (cpu_req_valid) begin
            req_tag_q   <= cpu_req_addr[AW-1:AW-TAG_W];
            req_index_q <= cpu_req_addr[OFF_W+INDEX_W-1:OFF_W];
            req_word_q  <= cpu_req_addr[OFF_W-1:2];
            req_data_q  <= cpu_req_data;
            req_rw_q    <= cpu_req_rw;
            state_q     <= StCompare;
          end
        end
        StCompare: begin
          refill_q <= 1'b0;
          if (hit) begin
            // The post-fill hit was already counted as a miss.
            if (!refill_q) hit_count <= sat_inc(hit_count);
            if (!req_rw_q) begin
              cpu_res_ready <= 1'b1;
              cpu_res_data  <= cur_line[req_word_q];
              state_q       <= StIdle;
            end else if (WRITE_BACK) begin
              dirty_q[req_index_q] <= 1'b1;
              cpu_res_ready        <= 1'b1;
              state_q              <= StIdle;
            end else begin
              mem_req_valid <= 1'b1;
              mem_req_rw    <= 1'b1;
              mem_req_addr  <= {req_tag_q, req_index_q, {OFF_W{1'b0}}};
              mem_req_data  <= upd_line;
              state_q       <= StWriteThru;
            end
          end else begin
            miss_count    <= sat_inc(miss_count);
            mem_req_valid <= 1'b1;
            if (valid_q[req_index_q] && dirty_q[req_index_q]) begin
              mem_req_rw   <= 1'b1;
              mem_req_addr <= {cur_tag, req_index_q, {OFF_W{1'b0}}};
              mem_req_data <= cur_line;
              state_q      <= StWriteBack;
            end else begin
              mem_req_rw   <= 1'b0;
              mem_req_addr <= {req_tag_q, req_index_q, {OFF_W{1'b0}}};
              state_q      <= StAllocate;
            end
          end
        end
        StWriteBack: begin
          if (mem_ack) begin
            mem_req_rw   <= 1'b0;
            mem_req_addr <= {req_tag_q, req_index_q, {OFF_W{1'b0}}};
            state_q      <= StAllocate;
          end
        end
        StAllocate: begin
          if (mem_ack) begin
            valid_q[req_index_q] <= 1'b1;
            dirty_q[req_index_q] <= 1'b0;
            mem_req_valid        <= 1'b0;
            refill_q             <= 1'b1;
            state_q              <= StCompare;
          end
        end
        StWriteThru: begin
          if (mem_ack) begin
            mem_req_valid <= 1'b0;
            mem_req_rw    <= 1'b0;
            cpu_res_ready <= 1'b1;
            state_q       <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_ctrl_param.sv
// Bench for cache_ctrl_param: a write-back instance (slot 0) and a write-through
// instance (slot 1), each with its own behavioural memory, checked against a
// word-level shadow memory and a tag/valid/dirty model of the cache.
module tb_cache_ctrl_param;

  typedef struct {
    bit           rw;
    logic [31:0]  addr;
    logic [127:0] data;
  } mreq_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [31:0]  cpu_req_addr  [2];
  logic [31:0]  cpu_req_data  [2];
  logic         cpu_req_rw    [2];
  logic         cpu_req_valid [2];
  logic [31:0]  cpu_res_data  [2];
  logic         cpu_res_ready [2];
  logic [31:0]  mem_req_addr  [2];
  logic [127:0] mem_req_data  [2];
  logic         mem_req_rw    [2];
  logic         mem_req_valid [2];
  logic [127:0] mem_data      [2];
  logic         mem_ready     [2];
  logic [31:0]  hit_count     [2];
  logic [31:0]  miss_count    [2];

  always #5 clk = ~clk;

  cache_ctrl_param #(.WRITE_BACK(1'b1)) dut_wb (
    .clk(clk), .rst_n(rst_n),
    .cpu_req_addr(cpu_req_addr[0]), .cpu_req_data(cpu_req_data[0]),
    .cpu_req_rw(cpu_req_rw[0]), .cpu_req_valid(cpu_req_valid[0]),
    .cpu_res_data(cpu_res_data[0]), .cpu_res_ready(cpu_res_ready[0]),
    .mem_req_addr(mem_req_addr[0]), .mem_req_data(mem_req_data[0]),
    .mem_req_rw(mem_req_rw[0]), .mem_req_valid(mem_req_valid[0]),
    .mem_data(mem_data[0]), .mem_ready(mem_ready[0]),
    .hit_count(hit_count[0]), .miss_count(miss_count[0])
  );

  cache_ctrl_param #(.WRITE_BACK(1'b0)) dut_wt (
    .clk(clk), .rst_n(rst_n),
    .cpu_req_addr(cpu_req_addr[1]), .cpu_req_data(cpu_req_data[1]),
    .cpu_req_rw(cpu_req_rw[1]), .cpu_req_valid(cpu_req_valid[1]),
    .cpu_res_data(cpu_res_data[1]), .cpu_res_ready(cpu_res_ready[1]),
    .mem_req_addr(mem_req_addr[1]), .mem_req_data(mem_req_data[1]),
    .mem_req_rw(mem_req_rw[1]), .mem_req_valid(mem_req_valid[1]),
    .mem_data(mem_data[1]), .mem_ready(mem_ready[1]),
    .hit_count(hit_count[1]), .miss_count(miss_count[1])
  );

  int n_pass = 0;
  int n_total = 0;
  int n_fail = 0;

  // Reference model: cache directory per slot plus word-level shadow memory.
  bit           ref_valid [2][1024];
  bit           ref_dirty [2][1024];
  logic [17:0]  ref_tag   [2][1024];
  int           exp_hits  [2];
  int           exp_miss  [2];
  logic [31:0]  ref_word  [bit [32:0]];
  logic [127:0] bmem      [bit [32:0]];

  int           delay  [2];
  bit           stray  [2];
  int           wait_c [2];
  mreq_t        cap    [2];
  mreq_t        log_q  [$];
  logic [9:0]   idx_tab [4] = '{10'h000, 10'h001, 10'h155, 10'h3FF};

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input int d, input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ ((d == 1) ? 32'h0F0F_0000 : 32'h5555_AAAA);
  endfunction

  function automatic logic [127:0] dflt_line(input int d, input logic [31:0] la);
    return {init_word(d, la + 32'd12), init_word(d, la + 32'd8),
            init_word(d, la + 32'd4), init_word(d, la)};
  endfunction

  function automatic logic [31:0] ref_rd(input int d, input logic [31:0] wa);
    bit [32:0] k;
    k = {d[0], wa};
    return ref_word.exists(k) ? ref_word[k] : init_word(d, wa);
  endfunction

  function automatic logic [127:0] ref_line(input int d, input logic [31:0] la);
    return {ref_rd(d, la + 32'd12), ref_rd(d, la + 32'd8), ref_rd(d, la + 32'd4), ref_rd(d, la)};
  endfunction

  task automatic clear_model();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 1024; i++) begin
        ref_valid[d][i] = 1'b0;
        ref_dirty[d][i] = 1'b0;
      end
      exp_hits[d] = 0;
      exp_miss[d] = 0;
    end
    ref_word.delete();
    bmem.delete();
  endtask

  task automatic preload(input int d, input logic [31:0] la, input logic [127:0] line);
    logic [31:0] wa;
    bmem[{d[0], la}] = line;
    for (int i = 0; i < 4; i++) begin
      wa = la + 32'(i * 4);
      ref_word[{d[0], wa}] = line[32*i +: 32];
    end
  endtask

  // Memory responder: answers after delay[d] extra cycles and checks the request holds still.
  always @(negedge clk) begin
    bit [32:0] k;
    for (int d = 0; d < 2; d++) begin
      mem_ready[d] = 1'b0;
      if (stray[d]) begin
        stray[d]     = 1'b0;
        mem_ready[d] = 1'b1;
        mem_data[d]  = '1;
      end else if (rst_n && mem_req_valid[d]) begin
        if (wait_c[d] == 0) begin
          cap[d].rw   = mem_req_rw[d];
          cap[d].addr = mem_req_addr[d];
          cap[d].data = mem_req_data[d];
        end else begin
          chk("mem_req stable while waiting",
              {mem_req_rw[d], mem_req_addr[d], mem_req_data[d]},
              {cap[d].rw, cap[d].addr, cap[d].data});
        end
        if (wait_c[d] >= delay[d]) begin
          k = {d[0], mem_req_addr[d]};
          if (mem_req_rw[d]) bmem[k] = mem_req_data[d];
          else mem_data[d] = bmem.exists(k) ? bmem[k] : dflt_line(d, mem_req_addr[d]);
          mem_ready[d] = 1'b1;
          log_q.push_back(cap[d]);
          wait_c[d] = 0;
        end else begin
          wait_c[d]++;
        end
      end else begin
        wait_c[d] = 0;
      end
    end
  end

  // One CPU transaction, checked against the model; starts and ends just after a negedge.
  task automatic xact(input int d, input logic [31:0] addr, input bit rw, input logic [31:0] wdata,
                      output logic [31:0] rdata, output int lat);
    int          idx;
    logic [17:0] tg;
    logic [31:0] la, wa, va;
    bit          hit, wb, wt;
    mreq_t       exp_q [$];
    idx = int'(addr[13:4]);
    tg  = addr[31:14];
    la  = {addr[31:4], 4'h0};
    wa  = {addr[31:2], 2'b00};
    wt  = (d == 1);
    hit = ref_valid[d][idx] && (ref_tag[d][idx] == tg);
    wb  = !hit && ref_valid[d][idx] && ref_dirty[d][idx];
    if (wb) begin
      va = {ref_tag[d][idx], addr[13:4], 4'h0};
      exp_q.push_back('{1'b1, va, ref_line(d, va)});
    end
    if (!hit) exp_q.push_back('{1'b0, la, '0});
    if (rw) ref_word[{d[0], wa}] = wdata;
    if (wt && rw) exp_q.push_back('{1'b1, la, ref_line(d, la)});
    if (hit) exp_hits[d]++;
    else exp_miss[d]++;

    log_q.delete();
    cpu_req_addr[d]  = addr;
    cpu_req_data[d]  = wdata;
    cpu_req_rw[d]    = rw;
    cpu_req_valid[d] = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      cpu_req_valid[d] = 1'b0;
    end while (!cpu_res_ready[d] && lat < 200);
    chk("cpu_res_ready within bound", cpu_res_ready[d], 1'b1);
    rdata = cpu_res_data[d];
    @(negedge clk);
    chk("cpu_res_ready single pulse", cpu_res_ready[d], 1'b0);
    chk("cpu_res_data holds", cpu_res_data[d], rdata);
    if (!rw) chk("read data", rdata, ref_rd(d, wa));
    chk("hit_count", hit_count[d], exp_hits[d]);
    chk("miss_count", miss_count[d], exp_miss[d]);
    chk("mem request count", log_q.size(), exp_q.size());
    foreach (exp_q[i]) begin
      if (i < log_q.size()) begin
        chk("mem request rw/addr", {log_q[i].rw, log_q[i].addr}, {exp_q[i].rw, exp_q[i].addr});
        if (exp_q[i].rw) chk("mem write line", log_q[i].data, exp_q[i].data);
      end
    end

    if (!hit) begin
      ref_valid[d][idx] = 1'b1;
      ref_tag[d][idx]   = tg;
      ref_dirty[d][idx] = 1'b0;
    end
    if (rw && !wt) ref_dirty[d][idx] = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int          lat;
    bit          seen;
    int          rd_d;
    logic [31:0] ra;

    for (int d = 0; d < 2; d++) begin
      cpu_req_addr[d]  = '0;
      cpu_req_data[d]  = '0;
      cpu_req_rw[d]    = 1'b0;
      cpu_req_valid[d] = 1'b0;
      delay[d]         = 0;
      stray[d]         = 1'b0;
      wait_c[d]        = 0;
    end
    clear_model();
    repeat (2) @(negedge clk);

    // Reset state on both instances.
    for (int d = 0; d < 2; d++) begin
      chk("reset cpu_res_ready", cpu_res_ready[d], 1'b0);
      chk("reset cpu_res_data", cpu_res_data[d], 32'h0);
      chk("reset mem_req_valid", mem_req_valid[d], 1'b0);
      chk("reset mem_req_rw", mem_req_rw[d], 1'b0);
      chk("reset mem_req_addr", mem_req_addr[d], 32'h0);
      chk("reset mem_req_data", mem_req_data[d], 128'h0);
      chk("reset hit_count", hit_count[d], 32'h0);
      chk("reset miss_count", miss_count[d], 32'h0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Cold read miss fills the line and returns word 1.
    preload(0, 32'h0000_1000, 128'h44444444_33333333_22222222_11111111);
    xact(0, 32'h0000_1004, 1'b0, 32'h0, rd, lat);
    chk("cold read data", rd, 32'h2222_2222);
    chk("cold read miss_count", miss_count[0], 32'd1);
    chk("cold read latency", lat, 4);

    // Re-read is a hit answered one cycle after acceptance.
    xact(0, 32'h0000_1004, 1'b0, 32'h0, rd, lat);
    chk("hit latency", lat, 2);
    chk("hit count after re-read", hit_count[0], 32'd1);

    // Dirty line is written back before the conflicting line is fetched.
    xact(0, 32'h0000_1008, 1'b1, 32'hDEAD_BEEF, rd, lat);
    xact(0, 32'h0001_1008, 1'b0, 32'h0, rd, lat);
    if (log_q.size() == 2) begin
      chk("write-back line", {log_q[0].rw, log_q[0].addr, log_q[0].data},
          {1'b1, 32'h0000_1000, 128'h44444444_DEADBEEF_22222222_11111111});
      chk("fetch after write-back", {log_q[1].rw, log_q[1].addr}, {1'b0, 32'h0001_1000});
    end
    chk("miss_count after eviction", miss_count[0], 32'd2);

    // Slow memory: request must stay put, one completion pulse.
    delay[0] = 5;
    xact(0, 32'h0002_2010, 1'b0, 32'h0, rd, lat);
    chk("slow memory latency", lat, 9);
    repeat (4) begin
      @(negedge clk);
      chk("no extra cpu_res_ready", cpu_res_ready[0], 1'b0);
    end
    delay[0] = 0;

    // Write-through instance.
    preload(1, 32'h0000_1000, 128'h44444444_33333333_22222222_11111111);
    xact(1, 32'h0000_1000, 1'b0, 32'h0, rd, lat);
    chk("wt fill read", rd, 32'h1111_1111);
    xact(1, 32'h0000_1000, 1'b1, 32'h1234_5678, rd, lat);
    chk("wt ready waits for memory", lat, 3);
    if (log_q.size() == 1) begin
      chk("wt line written", {log_q[0].rw, log_q[0].addr, log_q[0].data},
          {1'b1, 32'h0000_1000, 128'h44444444_33333333_22222222_12345678});
    end
    chk("wt hit_count", hit_count[1], 32'd1);
    xact(1, 32'h0001_1000, 1'b0, 32'h0, rd, lat);
    chk("wt eviction has no write-back", log_q.size(), 1);

    // Reset in the middle of a line fill.
    delay[0] = 8;
    cpu_req_addr[0]  = 32'h0003_3000;
    cpu_req_rw[0]    = 1'b0;
    cpu_req_valid[0] = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      cpu_req_valid[0] = 1'b0;
      seen = mem_req_valid[0] && !mem_req_rw[0];
    end
    chk("fill request reached", seen, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("reset drops mem_req_valid at once", mem_req_valid[0], 1'b0);
    chk("reset clears mem_req_addr at once", mem_req_addr[0], 32'h0);
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;
    stray[0] = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("stale mem_ready ignored (valid)", mem_req_valid[0], 1'b0);
      chk("stale mem_ready ignored (ready)", cpu_res_ready[0], 1'b0);
    end
    delay[0] = 0;
    xact(0, 32'h0003_3000, 1'b0, 32'h0, rd, lat);
    chk("re-read after abort misses", miss_count[0], 32'd1);

    // Randomised traffic over a few conflicting tags and indices.
    rst_n = 1'b0;
    clear_model();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int n = 0; n < 250; n++) begin
      rd_d = int'($urandom_range(0, 1));
      delay[rd_d] = int'($urandom_range(0, 3));
      ra = {18'($urandom_range(0, 3) * 7 + 1), idx_tab[$urandom_range(0, 3)],
            2'($urandom_range(0, 3)), 2'b00};
      xact(rd_d, ra, 1'($urandom_range(0, 1)), $urandom, rd, lat);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cache_ctrl_param.md
CACHE_CTRL_PARAM -- requirements
Module: cache_ctrl_param

Interface
REQ-001 SHALL have parameter AW, default 32, byte-address width.
REQ-002 SHALL have parameter INDEX_W, default 10, set-index bits (2^INDEX_W lines, direct-mapped).
REQ-003 SHALL have parameter WORDS, default 4, 32-bit words per line, power of two >=2; LINE_W=32*WORDS; OFF_W=2+log2(WORDS); TAG_W=AW-INDEX_W-OFF_W (defaults: 128, 4, 18).
REQ-004 SHALL have parameter WRITE_BACK, default 1; 1 = write-back, 0 = write-through.
REQ-005 SHALL have one clock; reset is asynchronous and active-low: clk input 1 rising-edge clock; rst_n input 1 async active-low reset.
REQ-006 SHALL have: cpu_req_addr in AW; cpu_req_data in 32 write data; cpu_req_rw in 1 (0 read, 1 write); cpu_req_valid in 1.
REQ-007 SHALL have: cpu_res_data out 32; cpu_res_ready out 1, one-cycle completion pulse.
REQ-008 SHALL have: mem_req_addr out AW line-aligned; mem_req_data out LINE_W; mem_req_rw out 1; mem_req_valid out 1.
REQ-009 SHALL have: mem_data in LINE_W read line; mem_ready in 1 memory completion.
REQ-010 SHALL have: hit_count out 32; miss_count out 32.

Function
REQ-011 SHALL decompose address: offset [OFF_W-1:0], word select [OFF_W-1:2], index [OFF_W+INDEX_W-1:OFF_W], tag [AW-1:AW-TAG_W].
REQ-012 SHALL store per line: valid, dirty, tag (TAG_W), data (LINE_W); only valid bits reset.
REQ-013 SHALL implement FSM states IDLE, COMPARE, WRITE_BACK, ALLOCATE, WRITE_THRU.
REQ-014 IDLE: cpu_req_valid=1 -> latch addr/data/rw, go COMPARE; otherwise stay; requests ignored in all other states.
REQ-015 COMPARE hit (valid & tag match): read -> cpu_res_ready=1, cpu_res_data=selected word, hit_count+1, go IDLE.
REQ-016 COMPARE write hit, WRITE_BACK=1: update selected word, dirty=1, cpu_res_ready=1, hit_count+1, go IDLE.
REQ-017 COMPARE write hit, WRITE_BACK=0: update word, dirty stays 0, hit_count+1, go WRITE_THRU without ready.
REQ-018 COMPARE miss: miss_count+1; victim valid & dirty -> WRITE_BACK, else ALLOCATE.
REQ-019 WRITE_BACK: mem_req_valid=1, rw=1, addr={victim tag, index, 0}, data=victim line; on mem_ready go ALLOCATE.
REQ-020 ALLOCATE: mem_req_valid=1, rw=0, addr={req tag, index, 0}; on mem_ready write mem_data, tag, valid=1, dirty=0, go COMPARE (that re-COMPARE is a hit and SHALL NOT increment hit_count).
REQ-021 WRITE_THRU: mem_req_valid=1, rw=1, addr={tag, index, 0}, data=updated line; on mem_ready cpu_res_ready=1, go IDLE.
REQ-022 mem_req_* SHALL be registered and stable while mem_req_valid=1; mem_ready ignored when mem_req_valid=0.
REQ-023 Latency: hit result in cycle after acceptance; miss = 1 + memory cycles + 1.
REQ-024 hit_count/miss_count SHALL saturate at 0xFFFF_FFFF.
REQ-025 cpu_res_data SHALL hold last returned value when cpu_res_ready=0.

Reset
REQ-026 rst_n=0 SHALL immediately force IDLE, all valid=0, all dirty=0, counters=0, cpu_res_ready=0, cpu_res_data=0, mem_req_valid=0, mem_req_rw=0, mem_req_addr=0, mem_req_data=0.
REQ-027 Reset mid-transaction SHALL abort it; in-flight memory response after release SHALL be ignored.

Verification
REQ-028 Defaults: reset, read 0x0000_1004 -> mem read 0x0000_1000; reply 0x44444444_33333333_22222222_11111111 -> cpu_res_data=0x2222_2222, miss_count=1.
REQ-029 Re-read 0x0000_1004 -> cpu_res_ready one cycle after acceptance, no mem_req_valid, hit_count=1.
REQ-030 Write 0xDEAD_BEEF to 0x0000_1008, then read 0x0001_1008 -> mem write 0x0000_1000 with word2=0xDEAD_BEEF, then mem read 0x0001_1000, miss_count=2.
REQ-031 WRITE_BACK=0: write hit 0x0000_1000 data 0x1234_5678 -> mem write 0x0000_1000 word0=0x1234_5678; cpu_res_ready only after mem_ready; no later write-back on eviction.
REQ-032 Assert rst_n during ALLOCATE -> mem_req_valid=0 same cycle, state IDLE; re-read same address misses.
REQ-033 mem_ready delayed 5 cycles -> mem_req_* unchanged throughout, single cpu_res_ready pulse.
